bmp_stream_loader: RTL and testbench

//  Parses an uncompressed BMP byte stream from sd_file_reader (outbyte/outen) and writes pixels to
//  the framebuffer write port as packed RGB888, one pixel per write strobe. Parametrised successor
//  of the fixed 640x480/24bpp/54-byte-header load path. Adds header parsing, 24/32 bpp, row padding,

---
 rtl/bmp_stream_loader.sv | 261 ++++++++++++++++++++++++++
 tb/tb_bmp_stream_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_loader.sv
// bmp_stream_loader: parses an uncompressed 24/32 bpp BMP byte stream and writes RGB888 pixels
// into a framebuffer. Define BMP_LOADER_CROP_EN to accept oversized images and crop them.
module bmp_stream_loader #(
    parameter int unsigned MAX_WIDTH  = 640,
    parameter int unsigned MAX_HEIGHT = 480,
    parameter int unsigned FB_STRIDE  = 640,
    parameter int unsigned ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_enable,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [23:0]           wr_data,
    output logic [11:0]           img_width,
    output logic [11:0]           img_height,
    output logic [3:0]            status,
    output logic [2:0]            err_code,
    output logic                  done
);

`ifdef BMP_LOADER_CROP_EN
    localparam int unsigned XW = 32;
    localparam int unsigned YW = 32;
`else
    localparam int unsigned XW = $clog2(MAX_WIDTH + 1);
    localparam int unsigned YW = $clog2(MAX_HEIGHT + 1);
`endif

    localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(FB_STRIDE);

    localparam logic [3:0] ST_IDLE = 4'h0;
    localparam logic [3:0] ST_HDR  = 4'h2;
    localparam logic [3:0] ST_LOAD = 4'h3;
    localparam logic [3:0] ST_DONE = 4'h4;
    localparam logic [3:0] ST_ERR  = 4'hE;

    localparam logic [2:0] ERR_MAGIC  = 3'd1;
    localparam logic [2:0] ERR_BPP    = 3'd2;
    localparam logic [2:0] ERR_COMP   = 3'd3;
    localparam logic [2:0] ERR_SIZE   = 3'd4;
    localparam logic [2:0] ERR_OFFSET = 3'd5;
    localparam logic [2:0] ERR_LOST   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_HEADER, S_SKIP, S_PIXEL, S_PAD, S_DONE, S_ERROR
    } state_t;

    state_t                state;
    logic [31:0]           byte_cnt;
    logic [31:0]           offset_r;
    logic [31:0]           width_r;
    logic [31:0]           height_r;
    logic [15:0]           bpp_r;
    logic [23:0]           comp_r;
    logic                  magic_ok;
    logic                  bpp32;
    logic                  topdown;
    logic [1:0]            pad_len;
    logic [1:0]            pad_cnt;
    logic [1:0]            phase;
    logic [XW-1:0]         x_cnt;
    logic [YW-1:0]         row_cnt;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [7:0]            b_r;
    logic [7:0]            g_r;
    logic [7:0]            r_r;
`ifdef BMP_LOADER_CROP_EN
    logic [YW-1:0]         y_img;
`endif

    logic [31:0] h_abs;
    logic [31:0] comp_full;
    logic [1:0]  lane;
    logic        size_bad;
    logic [2:0]  hdr_err;
    logic        pix_last;
    logic [23:0] pix_data;
    logic        row_end;
    logic        last_row;
    logic        wr_ok;

    // All 32-bit header fields start at an index == 2 mod 4, so the byte lane is idx[1:0]^2.
    assign lane      = byte_cnt[1:0] ^ 2'b10;
    assign h_abs     = height_r[31] ? (32'd0 - height_r) : height_r;
    assign comp_full = {in_byte, comp_r};
    assign pix_last  = (phase == 2'd3) || ((phase == 2'd2) && !bpp32);
    assign pix_data  = (phase == 2'd3) ? {r_r, g_r, b_r} : {in_byte, g_r, b_r};
    assign row_end   = (x_cnt == XW'(width_r - 32'd1));
    assign last_row  = (row_cnt == YW'(h_abs - 32'd1));

`ifdef BMP_LOADER_CROP_EN
    assign size_bad = (width_r == 32'd0) || (h_abs == 32'd0);
    assign wr_ok    = (x_cnt < XW'(MAX_WIDTH)) && (y_img < YW'(MAX_HEIGHT));
`else
    assign size_bad = (width_r == 32'd0) || (h_abs == 32'd0) ||
                      (width_r > 32'(MAX_WIDTH)) || (h_abs > 32'(MAX_HEIGHT));
    assign wr_ok    = 1'b1;
`endif

    // Lowest failing header check, evaluated while byte 33 is on the bus.
    always_comb begin
        hdr_err = 3'd0;
        if (!magic_ok)                                       hdr_err = ERR_MAGIC;
        else if ((bpp_r != 16'd24) && (bpp_r != 16'd32))     hdr_err = ERR_BPP;
        else if (comp_full != 32'd0)                         hdr_err = ERR_COMP;
        else if (size_bad)                                   hdr_err = ERR_SIZE;
        else if (offset_r < 32'd54)                          hdr_err = ERR_OFFSET;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            byte_cnt   <= '0;
            offset_r   <= '0;
            width_r    <= '0;
            height_r   <= '0;
            bpp_r      <= '0;
            comp_r     <= '0;
            magic_ok   <= 1'b0;
            bpp32      <= 1'b0;
            topdown    <= 1'b0;
            pad_len    <= '0;
            pad_cnt    <= '0;
            phase      <= '0;
            x_cnt      <= '0;
            row_cnt    <= '0;
            row_base   <= '0;
            b_r        <= '0;
            g_r        <= '0;
            r_r        <= '0;
`ifdef BMP_LOADER_CROP_EN
            y_img      <= '0;
`endif
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            img_width  <= '0;
            img_height <= '0;
            status     <= ST_IDLE;
            err_code   <= '0;
            done       <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    if (in_valid && in_enable) begin
                        byte_cnt <= 32'd1;
                        magic_ok <= (in_byte == 8'h42);
                        offset_r <= '0;
                        width_r  <= '0;
                        height_r <= '0;
                        bpp_r    <= '0;
                        comp_r   <= '0;
                        state    <= S_HEADER;
                        status   <= ST_HDR;
                    end
                end

                S_HEADER, S_SKIP, S_PIXEL, S_PAD: begin
                    if (!in_enable) begin
                        state    <= S_ERROR;
                        status   <= ST_ERR;
                        err_code <= ERR_LOST;
                    end else if (in_valid) begin
                        byte_cnt <= byte_cnt + 32'd1;
                        if (state == S_HEADER) begin
                            if (byte_cnt == 32'd1)
                                magic_ok <= magic_ok && (in_byte == 8'h4D);
                            if ((byte_cnt >= 32'd10) && (byte_cnt <= 32'd13))
                                offset_r[{lane, 3'b000} +: 8] <= in_byte;
                            if ((byte_cnt >= 32'd18) && (byte_cnt <= 32'd21))
                                width_r[{lane, 3'b000} +: 8] <= in_byte;
                            if ((byte_cnt >= 32'd22) && (byte_cnt <= 32'd25))
                                height_r[{lane, 3'b000} +: 8] <= in_byte;
                            if ((byte_cnt >= 32'd28) && (byte_cnt <= 32'd29))
                                bpp_r[{byte_cnt[0], 3'b000} +: 8] <= in_byte;
                            if ((byte_cnt >= 32'd30) && (byte_cnt <= 32'd32))
                                comp_r[{lane, 3'b000} +: 8] <= in_byte;
                            // Start row is resolved long before the first pixel byte.
                            if (byte_cnt == 32'd26) begin
                                img_width  <= width_r[11:0];
                                img_height <= h_abs[11:0];
                                topdown    <= height_r[31];
                                row_base   <= height_r[31] ? '0 :
                                              ADDR_WIDTH'((h_abs - 32'd1) * 32'(FB_STRIDE));
`ifdef BMP_LOADER_CROP_EN
                                y_img      <= height_r[31] ? '0 : YW'(h_abs - 32'd1);
`endif
                            end
                            if (byte_cnt == 32'd33) begin
                                if (hdr_err != 3'd0) begin
                                    state    <= S_ERROR;
                                    status   <= ST_ERR;
                                    err_code <= hdr_err;
                                end else begin
                                    bpp32   <= (bpp_r == 16'd32);
                                    pad_len <= (bpp_r == 16'd32) ? 2'd0 : width_r[1:0];
                                end
                            end
                            if (byte_cnt == 32'd34) begin
                                state   <= S_SKIP;
                                x_cnt   <= '0;
                                row_cnt <= '0;
                                phase   <= '0;
                            end
                        end else if (state == S_SKIP) begin
                            if (byte_cnt == offset_r - 32'd1) begin
                                state  <= S_PIXEL;
                                status <= ST_LOAD;
                            end
                        end else if (state == S_PAD) begin
                            if (pad_cnt == pad_len - 2'd1)
                                state <= S_PIXEL;
                            else
                                pad_cnt <= pad_cnt + 2'd1;
                        end else if (pix_last) begin
                            phase   <= '0;
                            wr_en   <= wr_ok;
                            wr_data <= pix_data;
                            wr_addr <= row_base + ADDR_WIDTH'(x_cnt);
                            if (row_end) begin
                                x_cnt    <= '0;
                                row_cnt  <= row_cnt + YW'(1);
                                row_base <= topdown ? (row_base + STRIDE_A) : (row_base - STRIDE_A);
`ifdef BMP_LOADER_CROP_EN
                                y_img    <= topdown ? (y_img + YW'(1)) : (y_img - YW'(1));
`endif
                                if (last_row) begin
                                    state  <= S_DONE;
                                    status <= ST_DONE;
                                    done   <= 1'b1;
                                end else if (pad_len != 2'd0) begin
                                    state   <= S_PAD;
                                    pad_cnt <= '0;
                                end
                            end else begin
                                x_cnt <= x_cnt + XW'(1);
                            end
                        end else begin
                            phase <= phase + 2'd1;
                            case (phase)
                                2'd0:    b_r <= in_byte;
                                2'd1:    g_r <= in_byte;
                                default: r_r <= in_byte;
                            endcase
                        end
                    end
                end

                default: begin
                    // DONE and ERROR hold until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_stream_loader.sv
// Directed testbench for bmp_stream_loader: builds BMP byte streams and checks framebuffer writes.
module tb_bmp_stream_loader;
    localparam int unsigned AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_enable = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic [11:0]   img_width;
    logic [11:0]   img_height;
    logic [3:0]    status;
    logic [2:0]    err_code;
    logic          done;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]    stream[$];
    logic [AW-1:0] cap_addr[$];
    logic [23:0]   cap_data[$];

    bmp_stream_loader #(
        .MAX_WIDTH(640), .MAX_HEIGHT(480), .FB_STRIDE(640), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst(rst), .in_enable(in_enable), .in_valid(in_valid), .in_byte(in_byte),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .img_width(img_width),
        .img_height(img_height), .status(status), .err_code(err_code), .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
        end
    end

    task automatic do_reset();
        in_enable = 1'b0;
        in_valid  = 1'b0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cap_addr.delete();
        cap_data.delete();
    endtask

    // Header + filler up to the pixel offset, then pixels B=3k+1, G=3k+2, R=3k+3 (A=AA), then junk.
    task automatic build_bmp(input int w, input int h, input int bpp, input int off,
                             input int comp, input logic [7:0] m1, input bit with_pix);
        int k;
        int rows;
        int pad;
        stream.delete();
        for (int i = 0; i < 54; i++) stream.push_back(8'h00);
        stream[0]  = 8'h42;
        stream[1]  = m1;
        stream[26] = 8'h01;
        stream[28] = 8'(bpp);
        stream[29] = 8'(bpp >> 8);
        for (int i = 0; i < 4; i++) begin
            stream[10 + i] = 8'(off >> (8 * i));
            stream[18 + i] = 8'(w >> (8 * i));
            stream[22 + i] = 8'(h >> (8 * i));
            stream[30 + i] = 8'(comp >> (8 * i));
        end
        while (stream.size() < off) stream.push_back(8'hFF);
        if (with_pix) begin
            k    = 0;
            rows = (h < 0) ? -h : h;
            pad  = (bpp == 24) ? (4 - ((w * 3) % 4)) % 4 : 0;
            for (int r = 0; r < rows; r++) begin
                for (int x = 0; x < w; x++) begin
                    stream.push_back(8'(3 * k + 1));
                    stream.push_back(8'(3 * k + 2));
                    stream.push_back(8'(3 * k + 3));
                    if (bpp == 32) stream.push_back(8'hAA);
                    k++;
                end
                for (int p = 0; p < pad; p++) stream.push_back(8'h00);
            end
        end
        for (int i = 0; i < 4; i++) stream.push_back(8'h5A);
    endtask

    // gap: 0 back-to-back, >0 fixed idle cycles, <0 random 1..7 idle cycles.
    task automatic send_bytes(input int n, input int gap);
        int g;
        in_enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_byte  = stream[i];
            @(negedge clk);
            if (gap != 0) begin
                g = (gap < 0) ? int'($urandom_range(7, 1)) : gap;
                in_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if ({wr_en, wr_addr, wr_data, img_width, img_height, status, err_code, done} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got en=%0b addr=%0h data=%0h w=%0d h=%0d st=%0h err=%0d done=%0b want all 0",
                     wr_en, wr_addr, wr_data, img_width, img_height, status, err_code, done);
        end
    endtask

    task automatic test_bottom_up_24();
        logic [AW-1:0] ea[4] = '{19'd640, 19'd641, 19'd0, 19'd1};
        logic [23:0]   ed[4] = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
        do_reset();
        build_bmp(2, 2, 24, 54, 0, 8'h4D, 1'b1);
        send_bytes(stream.size(), 0);
        vec_cnt++;
        if (cap_addr.size() !== 4) begin
            err_cnt++; $display("FAIL bu24_count: got %0d want 4", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 4; i++) begin
            vec_cnt++;
            if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
                err_cnt++;
                $display("FAIL bu24_write%0d: got addr=%0d data=%06h want addr=%0d data=%06h",
                         i, cap_addr[i], cap_data[i], ea[i], ed[i]);
            end
        end
        vec_cnt++;
        if (done !== 1'b1 || status !== 4'h4 || err_code !== 3'd0) begin
            err_cnt++; $display("FAIL bu24_done: got done=%0b st=%0h err=%0d want 1/4/0", done, status, err_code);
        end
        vec_cnt++;
        if (img_width !== 12'd2 || img_height !== 12'd2) begin
            err_cnt++; $display("FAIL bu24_dims: got %0dx%0d want 2x2", img_width, img_height);
        end
    endtask

    task automatic test_top_down_32();
        logic [23:0] ed[3] = '{24'h030201, 24'h060504, 24'h090807};
        do_reset();
        build_bmp(3, -1, 32, 54, 0, 8'h4D, 1'b1);
        send_bytes(stream.size(), 0);
        vec_cnt++;
        if (cap_addr.size() !== 3) begin
            err_cnt++; $display("FAIL td32_count: got %0d want 3", cap_addr.size());
        end
        for (int i = 0; i < cap_addr.size() && i < 3; i++) begin
            vec_cnt++;
            if (cap_addr[i] !== AW'(i) || cap_data[i] !== ed[i]) begin
                err_cnt++;
                $display("FAIL td32_write%0d: got addr=%0d data=%06h want addr=%0d data=%06h",
                         i, cap_addr[i], cap_data[i], i, ed[i]);
            end
        end
        vec_cnt++;
        if (done !== 1'b1 || status !== 4'h4 || img_height !== 12'd1) begin
            err_cnt++; $display("FAIL td32_done: got done=%0b st=%0h h=%0d want 1/4/1", done, status, img_height);
        end
    endtask

    task automatic test_header_errors();
        int m1_t[7]  = '{'h4E, 'h4D, 'h4D, 'h4D, 'h4D, 'h4D, 'h4E};
        int bpp_t[7] = '{24, 16, 24, 24, 32, 24, 16};
        int cmp_t[7] = '{0, 0, 1, 0, 0, 0, 1};
        int w_t[7]   = '{2, 2, 2, 0, 2, 2, 0};
        int h_t[7]   = '{2, 2, 2, 2, 0, 2, 2};
        int off_t[7] = '{54, 54, 54, 54, 54, 40, 40};
        int exp_t[7] = '{1, 2, 3, 4, 4, 5, 1};
        for (int c = 0; c < 7; c++) begin
            do_reset();
            build_bmp(w_t[c], h_t[c], bpp_t[c], off_t[c], cmp_t[c], 8'(m1_t[c]), 1'b0);
            send_bytes(stream.size(), 0);
            vec_cnt++;
            if (err_code !== 3'(exp_t[c]) || status !== 4'hE || done !== 1'b0) begin
                err_cnt++;
                $display("FAIL hdr_err_case%0d: got err=%0d st=%0h done=%0b want err=%0d st=e done=0",
                         c, err_code, status, done, exp_t[c]);
            end
            vec_cnt++;
            if (cap_addr.size() !== 0) begin
                err_cnt++; $display("FAIL hdr_err_nowrite%0d: got %0d writes want 0", c, cap_addr.size());
            end
        end
    endtask

    task automatic test_skip_offset();
        int gaps[3] = '{0, 3, -1};
        for (int t = 0; t < 3; t++) begin
            do_reset();
            build_bmp(1, 1, 24, 138, 0, 8'h4D, 1'b1);
            send_bytes(stream.size(), gaps[t]);
            vec_cnt++;
            if (cap_addr.size() !== 1) begin
                err_cnt++; $display("FAIL skip_count_gap%0d: got %0d want 1", t, cap_addr.size());
            end else if (cap_addr[0] !== '0 || cap_data[0] !== 24'h030201) begin
                err_cnt++;
                $display("FAIL skip_write_gap%0d: got addr=%0d data=%06h want addr=0 data=030201",
                         t, cap_addr[0], cap_data[0]);
            end
            vec_cnt++;
            if (done !== 1'b1 || status !== 4'h4) begin
                err_cnt++; $display("FAIL skip_done_gap%0d: got done=%0b st=%0h want 1/4", t, done, status);
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        build_bmp(2, 2, 24, 54, 0, 8'h4D, 1'b1);
        send_bytes(58, 0);
        in_enable = 1'b0;
        repeat (2) @(negedge clk);
        vec_cnt++;
        if (err_code !== 3'd6 || status !== 4'hE || cap_addr.size() !== 1) begin
            err_cnt++;
            $display("FAIL enable_drop: got err=%0d st=%0h writes=%0d want err=6 st=e writes=1",
                     err_code, status, cap_addr.size());
        end
        // Reset lands together with the R byte of the first pixel.
        do_reset();
        send_bytes(56, 0);
        in_valid = 1'b1;
        in_byte  = stream[56];
        rst      = 1'b1;
        @(posedge clk);
        #1;
        vec_cnt++;
        if ({wr_en, wr_addr, wr_data, img_width, img_height, status, err_code, done} !== '0) begin
            err_cnt++;
            $display("FAIL rst_midpixel: got en=%0b addr=%0h data=%0h st=%0h err=%0d want all 0",
                     wr_en, wr_addr, wr_data, status, err_code);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (cap_addr.size() !== 0) begin
            err_cnt++; $display("FAIL rst_nowrite: got %0d writes want 0", cap_addr.size());
        end
        send_bytes(stream.size(), 0);
        vec_cnt++;
        if (cap_addr.size() !== 4 || done !== 1'b1) begin
            err_cnt++; $display("FAIL reload_count: got %0d writes done=%0b want 4/1", cap_addr.size(), done);
        end else if (cap_addr[0] !== 19'd640 || cap_addr[3] !== 19'd1 || cap_data[3] !== 24'h0C0B0A) begin
            err_cnt++;
            $display("FAIL reload_writes: got a0=%0d a3=%0d d3=%06h want 640/1/0c0b0a",
                     cap_addr[0], cap_addr[3], cap_data[3]);
        end
    endtask

    task automatic test_max_width();
        do_reset();
        build_bmp(640, 1, 24, 54, 0, 8'h4D, 1'b1);
        send_bytes(stream.size(), 0);
        vec_cnt++;
        if (cap_addr.size() !== 640 || done !== 1'b1) begin
            err_cnt++; $display("FAIL maxw_count: got %0d writes done=%0b want 640/1", cap_addr.size(), done);
        end else if (cap_addr[639] !== 19'd639 || cap_data[639] !== 24'h807F7E) begin
            err_cnt++;
            $display("FAIL maxw_last: got addr=%0d data=%06h want 639/807f7e", cap_addr[639], cap_data[639]);
        end
    endtask

    task automatic test_oversize();
        int bad;
        do_reset();
        build_bmp(800, 2, 24, 54, 0, 8'h4D, 1'b1);
        send_bytes(stream.size(), 0);
`ifdef BMP_LOADER_CROP_EN
        bad = 0;
        foreach (cap_addr[i]) if (cap_addr[i] >= 19'd1280) bad++;
        vec_cnt++;
        if (cap_addr.size() !== 1280 || bad !== 0 || done !== 1'b1) begin
            err_cnt++;
            $display("FAIL crop_writes: got %0d writes %0d out of range done=%0b want 1280/0/1",
                     cap_addr.size(), bad, done);
        end else if (cap_addr[0] !== 19'd640 || cap_data[0] !== 24'h030201) begin
            err_cnt++;
            $display("FAIL crop_first: got addr=%0d data=%06h want 640/030201", cap_addr[0], cap_data[0]);
        end
`else
        bad = cap_addr.size();
        vec_cnt++;
        if (err_code !== 3'd4 || status !== 4'hE || bad !== 0) begin
            err_cnt++;
            $display("FAIL oversize_w: got err=%0d st=%0h writes=%0d want 4/e/0", err_code, status, bad);
        end
        do_reset();
        build_bmp(2, 481, 24, 54, 0, 8'h4D, 1'b0);
        send_bytes(stream.size(), 0);
        vec_cnt++;
        if (err_code !== 3'd4 || status !== 4'hE) begin
            err_cnt++; $display("FAIL oversize_h: got err=%0d st=%0h want 4/e", err_code, status);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_bottom_up_24();
        test_top_down_32();
        test_header_errors();
        test_skip_offset();
        test_abort();
        test_max_width();
        test_oversize();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
